cla_operand_loader: RTL

Board-facing stage that feeds the 4-bit carry-lookahead adder. It captures operands A and B from the lab slide switches on debounced push-button presses and holds them stable on the adder inputs. It also registers the adder's 5-bit sum once both operands are present, so the display logic downstream sees a glitch-free result with a valid flag.

---
 rtl/cla_operand_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cla_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cla_operand_loader
//  Purpose  : Captures 4-bit operands A/B from slide switches on debounced
//             push-button presses, holds them on the carry-lookahead adder
//             inputs, and registers the adder's 5-bit sum with a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module cla_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_clr,
    input  logic [4:0] sum_in,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       a_loaded,
    output logic       b_loaded,
    output logic [4:0] result,
    output logic       result_valid
);

    // Counter value on which the next differing cycle toggles the debounced level.
    localparam logic [15:0] c_cnt_last = 16'(DEBOUNCE_CYCLES - 1);

    // Operand-state encoding: bit 1 = A loaded, bit 0 = B loaded.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        HAVE_B = 2'b01,
        HAVE_A = 2'b10,
        READY  = 2'b11
    } state_t;

    logic [3:0] r_sw_s1;
    logic [3:0] r_sw_s2;
    logic [2:0] w_btn_raw;
    logic [2:0] w_press;
    logic       w_press_a;
    logic       w_press_b;
    logic       w_press_clr;
    logic       w_any_load;
    logic [1:0] w_next_flags;
    state_t     r_state;
    logic       r_pending;

    assign w_btn_raw = {btn_clr, btn_b, btn_a};

    // Two-flop synchronizer for the switch bus; the switches are not debounced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_s1 <= 4'd0;
            r_sw_s2 <= 4'd0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic        r_s1;
        logic        r_s2;
        logic        r_deb;
        logic [15:0] r_cnt;
        logic        w_hit;

        // The debounced level flips on the cycle the disagreement count completes.
        assign w_hit      = (r_s2 != r_deb) && (r_cnt == c_cnt_last);
        // Only the rising transition of the debounced level is a press.
        assign w_press[i] = w_hit & ~r_deb;

        // Synchronize the raw button, then count consecutive disagreeing cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_deb <= 1'b0;
                r_cnt <= 16'd0;
            end else begin
                r_s1 <= w_btn_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_deb) begin
                    r_cnt <= 16'd0;
                end else if (w_hit) begin
                    r_deb <= ~r_deb;
                    r_cnt <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign w_press_a    = w_press[0];
    assign w_press_b    = w_press[1];
    assign w_press_clr  = w_press[2];
    assign w_any_load   = w_press_a | w_press_b;
    assign w_next_flags = {r_state[1] | w_press_a, r_state[0] | w_press_b};

    assign a_loaded = r_state[1];
    assign b_loaded = r_state[0];

    // Operand/state/result register: clear dominates, a load that completes
    // READY arms a capture one edge later so the adder has a cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a         <= 4'd0;
            op_b         <= 4'd0;
            r_state      <= EMPTY;
            result       <= 5'd0;
            result_valid <= 1'b0;
            r_pending    <= 1'b0;
        end else if (w_press_clr) begin
            op_a         <= 4'd0;
            op_b         <= 4'd0;
            r_state      <= EMPTY;
            result       <= 5'd0;
            result_valid <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            if (w_press_a) begin
                op_a <= r_sw_s2;
            end
            if (w_press_b) begin
                op_b <= r_sw_s2;
            end
            if (w_any_load) begin
                r_state <= state_t'(w_next_flags);
                if (w_next_flags == 2'b11) begin
                    // Any capture still pending refers to stale operands.
                    result_valid <= 1'b0;
                    r_pending    <= 1'b1;
                end
            end else if (r_pending) begin
                result       <= sum_in;
                result_valid <= 1'b1;
                r_pending    <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
